vram_rd_arbiter: RTL and testbench

- Shares the single VRAM read port between NUM_REQ video fetch clients: the sprite renderer, the tile/bitmap layer renderers, and the line-composer palette fetch.
- Each client uses the renderer bus protocol. The client holds strobe and address until a one-cycle ack, and data is valid in the ack cycle.
- Arbitration is round-robin. Accesses are pipelined, so one VRAM read can issue per cycle across different clients.
- Sits between the renderers and the VRAM read port, inside the video subsystem.

---
 rtl/vram_rd_arbiter.sv | 79 +++++++
 tb/tb_vram_rd_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rd_arbiter.sv
// vram_rd_arbiter: round-robin, pipelined sharing of the single VRAM read port among NUM_REQ fetch clients
//   clk, rst        : clock, synchronous active-high reset
//   req_strobe      : per-client read request, held until that client's ack
//   req_addr        : packed per-client word addresses, client i at [i*ADDR_W +: ADDR_W]
//   req_ack         : one-cycle completion pulse, at most one bit per cycle
//   req_rddata      : read data broadcast to all clients, valid with any req_ack bit
//   vram_rden/addr  : VRAM read command, one per cycle at most
//   vram_rddata     : VRAM read data, RD_LATENCY cycles after vram_rden
//   busy            : any read in flight
module vram_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_strobe,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_rddata,
    output logic                      vram_rden,
    output logic [ADDR_W-1:0]         vram_addr,
    input  logic [DATA_W-1:0]         vram_rddata,
    output logic                      busy
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] elig;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    // Stage 0 is the issue register driving vram_rden; stage RD_LATENCY lines up with vram_rddata.
    logic [RD_LATENCY:0] v_pipe;
    logic [IW-1:0]       i_pipe [RD_LATENCY+1];

    assign elig      = req_strobe & ~pending;
    assign busy      = |pending;
    assign vram_rden = v_pipe[0];

    // Walk downward so the eligible client closest to rr_ptr is the last one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (elig[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            rr_ptr     <= '0;
            v_pipe     <= '0;
            vram_addr  <= '0;
            req_ack    <= '0;
            req_rddata <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) i_pipe[k] <= '0;
        end else begin
            pending <= (pending & ~req_ack) | (gnt_vld ? NUM_REQ'(1) << gnt_idx : '0);
            if (gnt_vld) begin
                rr_ptr    <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                vram_addr <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            end
            v_pipe    <= {v_pipe[RD_LATENCY-1:0], gnt_vld};
            i_pipe[0] <= gnt_idx;
            for (int k = 1; k <= RD_LATENCY; k++) i_pipe[k] <= i_pipe[k-1];
            req_ack <= v_pipe[RD_LATENCY] ? NUM_REQ'(1) << i_pipe[RD_LATENCY] : '0;
            if (v_pipe[RD_LATENCY]) req_rddata <= vram_rddata;
        end
    end
endmodule

// File: tb/tb_vram_rd_arbiter.sv
// tb_vram_rd_arbiter: directed and random stimulus against a cycle-scheduled reference model of the arbiter
module tb_vram_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 15;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_strobe;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   req_rddata;
    logic            vram_rden;
    logic [AW-1:0]   vram_addr;
    logic [DW-1:0]   vram_rddata;
    logic            busy;

    vram_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_strobe(req_strobe), .req_addr(req_addr),
        .req_ack(req_ack), .req_rddata(req_rddata), .vram_rden(vram_rden),
        .vram_addr(vram_addr), .vram_rddata(vram_rddata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] vram_word(logic [AW-1:0] a);
        return (a == 15'h1234) ? 32'hDEADBEEF : {a, 2'b01, ~a};
    endfunction

    // VRAM with one cycle of read latency
    always @(posedge clk) if (vram_rden) vram_rddata <= vram_word(vram_addr);

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rden_cnt;
    int ack_cnt [N];

    // Reference model: pending set, pointer, and a schedule of expected outputs per future cycle.
    logic [N-1:0]  mp;
    int            ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [N-1:0]  last_ack;
    logic          e_rden [8];
    logic [AW-1:0] e_addr [8];
    logic [N-1:0]  e_ack  [8];
    logic [DW-1:0] e_data [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic clr_model();
        mp = '0; ptr = 0; m_addr = '0; m_data = '0;
        for (int i = 0; i < 8; i++) begin
            e_rden[i] = 1'b0; e_addr[i] = '0; e_ack[i] = '0; e_data[i] = '0;
        end
    endtask

    task automatic clr_counts();
        rden_cnt = 0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Called at a negedge with this cycle's inputs applied; checks, advances the model, moves to the next negedge.
    task automatic step();
        int s, g;
        bit found;
        logic [AW-1:0] a;
        s = cyc % 8;
        if (e_rden[s]) m_addr = e_addr[s];
        if (|e_ack[s]) m_data = e_data[s];
        check("rden", 64'(vram_rden), 64'(e_rden[s]));
        check("addr", 64'(vram_addr), 64'(m_addr));
        check("ack", 64'(req_ack), 64'(e_ack[s]));
        check("rddata", 64'(req_rddata), 64'(m_data));
        check("busy", 64'(busy), 64'(|mp));
        rden_cnt += int'(vram_rden);
        for (int i = 0; i < N; i++) if (req_ack[i]) ack_cnt[i]++;
        last_ack = e_ack[s];
        if (rst) begin
            clr_model();
        end else begin
            found = 1'b0; g = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr + k) % N;
                if (!found && req_strobe[j] && !mp[j]) begin found = 1'b1; g = j; end
            end
            mp = mp & ~e_ack[s];
            e_rden[s] = 1'b0; e_ack[s] = '0;
            if (found) begin
                a = req_addr[g*AW +: AW];
                mp[g] = 1'b1;
                ptr = (g + 1) % N;
                e_rden[(cyc + 1) % 8] = 1'b1;
                e_addr[(cyc + 1) % 8] = a;
                e_ack[(cyc + 3) % 8]  = N'(1) << g;
                e_data[(cyc + 3) % 8] = vram_word(a);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Clients drop their strobe after the model's ack; those in cont re-strobe at once with a fresh address.
    task automatic run(input int n, input logic [N-1:0] cont);
        repeat (n) begin
            step();
            for (int i = 0; i < N; i++) if (last_ack[i]) begin
                req_strobe[i] = cont[i];
                if (cont[i]) set_addr(i, AW'($urandom));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_strobe = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr_model();
    endtask

    initial begin
        req_addr = {N*AW{1'b1}};
        do_reset();
        clr_counts();
        check("rst_ack", 64'(req_ack), 64'(0));
        check("rst_rden", 64'(vram_rden), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // single read from client 2, strobe held through the ack cycle
        req_addr = {N*AW{1'b1}};
        set_addr(2, 15'h1234);
        req_strobe = 4'b0100;
        repeat (4) step();
        req_strobe = '0;
        repeat (3) step();
        check("t1_rden_cnt", 64'(rden_cnt), 64'(1));
        check("t1_ack_cnt", 64'(ack_cnt[2]), 64'(1));
        check("t1_data", 64'(req_rddata), 64'(32'hDEADBEEF));

        // four simultaneous requests
        do_reset(); clr_counts();
        for (int i = 0; i < N; i++) set_addr(i, AW'((i + 1) * 16));
        req_strobe = '1;
        run(9, '0);
        for (int i = 0; i < N; i++) check("t2_ack_cnt", 64'(ack_cnt[i]), 64'(1));
        check("t2_rden_cnt", 64'(rden_cnt), 64'(4));

        // clients 0 and 2 continuously re-strobing
        clr_counts();
        set_addr(0, 15'h0100); set_addr(2, 15'h0200);
        req_strobe = 4'b0101;
        run(42, 4'b0101);
        req_strobe = '0;
        run(5, '0);
        check("t3_c1", 64'(ack_cnt[1]), 64'(0));
        check("t3_c3", 64'(ack_cnt[3]), 64'(0));
        check("t3_total", 64'(ack_cnt[0] + ack_cnt[2] >= 20), 64'(1));
        check("t3_fair", 64'(ack_cnt[0] - ack_cnt[2] <= 1 && ack_cnt[2] - ack_cnt[0] <= 1), 64'(1));

        // strobe withdrawn before the ack
        do_reset(); clr_counts();
        set_addr(0, 15'h0ABC);
        req_strobe = 4'b0001;
        step();
        req_strobe = '0;
        repeat (3) step();
        check("t5_ack", 64'(ack_cnt[0]), 64'(1));
        set_addr(0, 15'h0DEF);
        req_strobe = 4'b0001;
        run(5, '0);
        check("t5_ack2", 64'(ack_cnt[0]), 64'(2));

        // reset with four reads in flight
        do_reset(); clr_counts();
        for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
        req_strobe = '1;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0; req_strobe = '0;
        clr_counts();
        repeat (5) step();
        check("t6_no_ack", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]), 64'(0));
        set_addr(3, 15'h7777);
        req_strobe = 4'b1000;
        run(5, '0);
        check("t6_served", 64'(ack_cnt[3]), 64'(1));

        // random traffic with aborts and occasional resets
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(199) == 0);
            for (int i = 0; i < N; i++) begin
                if (last_ack[i] && $urandom_range(1) == 0) req_strobe[i] = 1'b0;
                else if (req_strobe[i] && $urandom_range(24) == 0) req_strobe[i] = 1'b0;
                else if (!req_strobe[i] && $urandom_range(2) == 0) begin
                    req_strobe[i] = 1'b1;
                    set_addr(i, AW'($urandom));
                end
                if (!req_strobe[i]) set_addr(i, AW'($urandom));
            end
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
